// File: rtl/data_mem_responder.sv
// Single-port data memory for the MEM stage: accepts one request at a time, waits
// WAIT_CYCLES extra cycles, then performs the access and presents a held response.
module data_mem_responder #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rsp_valid_reg;
    logic              rsp_we_reg;
    logic [15:0]       rd_count_reg;
    logic [15:0]       wr_count_reg;
    logic              access;

    assign access = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);

    // Storage has no reset so it maps onto block RAM; the state-register guard on
    // access means an aborted write is never committed.
    always_ff @(posedge clk) begin
        if (access && we_reg) begin
            mem[addr_reg] <= wdata_reg;
        end
        if (access && !we_reg) begin
            rd_data_reg <= mem[addr_reg];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rd_count_reg  <= 16'd0;
            wr_count_reg  <= 16'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        cnt_reg   <= WAIT_INIT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        rsp_valid_reg <= 1'b1;
                        rsp_we_reg    <= we_reg;
                        state_reg     <= ST_RESP;
                        if (we_reg && wr_count_reg != 16'hFFFF) begin
                            wr_count_reg <= wr_count_reg + 16'd1;
                        end
                        if (!we_reg && rd_count_reg != 16'hFFFF) begin
                            rd_count_reg <= rd_count_reg + 16'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Write responses carry zero data; gating by rsp_valid also gives a clean reset value.
    assign rsp_rdata = (rsp_valid_reg && !rsp_we_reg) ? rd_data_reg : '0;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_we    = rsp_we_reg;
    assign req_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg != ST_IDLE);
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;

endmodule
